// File: rtl/ysyx_22041207_pipe_ctrl.sv
// ysyx_22041207_pipe_ctrl: hazard/stall scheduler for the 5-stage core.
// Sequences ME-stage AXI accesses, detects load-use hazards, holds EX redirects
// across memory stalls, and keeps saturating stall/flush counters plus a sticky
// AXI timeout flag. Stall/flush controls are combinational from state + inputs
// because they must steer the pipeline registers in the same cycle.
module ysyx_22041207_pipe_ctrl #(
  parameter int unsigned CNT_W    = 32,
  parameter int unsigned MAX_WAIT = 1023
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             if_busy_i,
  input  logic             me_mem_req_i,
  input  logic             me_axi_ready_i,
  input  logic             me_axi_done_i,
  input  logic             ex_redirect_i,
  input  logic             ex_is_load_i,
  input  logic [4:0]       ex_rd_i,
  input  logic [4:0]       id_rs1_i,
  input  logic [4:0]       id_rs2_i,
  input  logic             id_use_rs1_i,
  input  logic             id_use_rs2_i,
  output logic             me_axi_req_o,
  output logic             me_wait_for_axi_o,
  output logic             pc_stall_o,
  output logic             if_id_stall_o,
  output logic             if_id_flush_o,
  output logic             id_ex_stall_o,
  output logic             id_ex_bubble_o,
  output logic             me_wb_bubble_o,
  output logic             redirect_take_o,
  output logic             axi_timeout_o,
  output logic [CNT_W-1:0] stall_cycles_o,
  output logic [CNT_W-1:0] flush_count_o
);

  localparam int unsigned WCNT_W = $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {
    M_IDLE = 2'd0,
    M_REQ  = 2'd1,
    M_WAIT = 2'd2,
    M_DONE = 2'd3
  } mstate_e;

  mstate_e           state_q, state_d;
  logic              redir_pend_q, redir_pend_d;
  logic [WCNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              timeout_q, timeout_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

  logic mem_wait_c;
  logic redirect_c;
  logic load_use_c;
  logic timeout_hit_c;

  // ME memory sequencing: next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      M_IDLE: if (me_mem_req_i) state_d = M_REQ;
      M_REQ: begin
        if (me_axi_ready_i) begin
          state_d = me_axi_done_i ? M_DONE : M_WAIT;
        end
      end
      M_WAIT: if (me_axi_done_i) state_d = M_DONE;
      M_DONE: state_d = M_IDLE;
      default: state_d = M_IDLE;
    endcase
  end

  // Hazard qualifiers shared by the priority logic
  always_comb begin
    mem_wait_c = ((state_q == M_IDLE) && me_mem_req_i) ||
                 (state_q == M_REQ) || (state_q == M_WAIT);
    redirect_c = ex_redirect_i || redir_pend_q;
    load_use_c = ex_is_load_i && (ex_rd_i != 5'd0) &&
                 ((id_use_rs1_i && (id_rs1_i == ex_rd_i)) ||
                  (id_use_rs2_i && (id_rs2_i == ex_rd_i)));
  end

  // Prioritised stall/flush/bubble decode; memory stall wins, then redirect,
  // then load-use, then fetch busy. A redirect seen under a memory stall is parked.
  always_comb begin
    me_axi_req_o      = 1'b0;
    me_wait_for_axi_o = 1'b0;
    pc_stall_o        = 1'b0;
    if_id_stall_o     = 1'b0;
    if_id_flush_o     = 1'b0;
    id_ex_stall_o     = 1'b0;
    id_ex_bubble_o    = 1'b0;
    me_wb_bubble_o    = 1'b0;
    redirect_take_o   = 1'b0;
    redir_pend_d      = redir_pend_q;
    if (!rst) begin
      me_axi_req_o = (state_q == M_REQ);
      if (mem_wait_c) begin
        me_wait_for_axi_o = 1'b1;
        pc_stall_o        = 1'b1;
        if_id_stall_o     = 1'b1;
        id_ex_stall_o     = 1'b1;
        me_wb_bubble_o    = 1'b1;
        redir_pend_d      = redirect_c;
      end else if (redirect_c) begin
        redirect_take_o = 1'b1;
        if_id_flush_o   = 1'b1;
        id_ex_bubble_o  = 1'b1;
        redir_pend_d    = 1'b0;
      end else if (load_use_c) begin
        pc_stall_o     = 1'b1;
        if_id_stall_o  = 1'b1;
        id_ex_bubble_o = 1'b1;
      end else if (if_busy_i) begin
        pc_stall_o    = 1'b1;
        if_id_flush_o = 1'b1;
      end
    end
  end

  // AXI wait watchdog: wait_cnt holds the number of M_WAIT cycles including the current one
  always_comb begin
    wait_cnt_d    = '0;
    timeout_hit_c = (state_q == M_WAIT) && (wait_cnt_q == WCNT_W'(MAX_WAIT));
    timeout_d     = timeout_q || timeout_hit_c;
    if (state_d == M_WAIT) begin
      if (state_q != M_WAIT) begin
        wait_cnt_d = WCNT_W'(1);
      end else if (wait_cnt_q == WCNT_W'(MAX_WAIT)) begin
        wait_cnt_d = wait_cnt_q;
      end else begin
        wait_cnt_d = wait_cnt_q + WCNT_W'(1);
      end
    end
    axi_timeout_o = !rst && timeout_d;
  end

  // Saturating perf counters
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (pc_stall_o && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    if (redirect_take_o && (flush_cnt_q != {CNT_W{1'b1}})) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
    stall_cycles_o = stall_cnt_q;
    flush_count_o  = flush_cnt_q;
  end

  // State registers with synchronous active-high reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= M_IDLE;
      redir_pend_q <= 1'b0;
      wait_cnt_q   <= '0;
      timeout_q    <= 1'b0;
      stall_cnt_q  <= '0;
      flush_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      redir_pend_q <= redir_pend_d;
      wait_cnt_q   <= wait_cnt_d;
      timeout_q    <= timeout_d;
      stall_cnt_q  <= stall_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
    end
  end

endmodule

// File: tb/tb_ysyx_22041207_pipe_ctrl.sv
// Self-checking bench for ysyx_22041207_pipe_ctrl: directed scenarios plus a
// randomized run against a behavioural model of the scheduling rules.
module tb_ysyx_22041207_pipe_ctrl;

  localparam int unsigned CNT_W    = 8;
  localparam int unsigned MAX_WAIT = 8;
  localparam int          SAT      = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst;
  logic if_busy, me_mem_req, me_axi_ready, me_axi_done, ex_redirect, ex_is_load;
  logic [4:0] ex_rd, id_rs1, id_rs2;
  logic id_use_rs1, id_use_rs2;
  logic me_axi_req, me_wait_for_axi, pc_stall, if_id_stall, if_id_flush;
  logic id_ex_stall, id_ex_bubble, me_wb_bubble, redirect_take, axi_timeout;
  logic [CNT_W-1:0] stall_cycles, flush_count;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ysyx_22041207_pipe_ctrl #(.CNT_W(CNT_W), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst(rst),
    .if_busy_i(if_busy), .me_mem_req_i(me_mem_req), .me_axi_ready_i(me_axi_ready),
    .me_axi_done_i(me_axi_done), .ex_redirect_i(ex_redirect), .ex_is_load_i(ex_is_load),
    .ex_rd_i(ex_rd), .id_rs1_i(id_rs1), .id_rs2_i(id_rs2),
    .id_use_rs1_i(id_use_rs1), .id_use_rs2_i(id_use_rs2),
    .me_axi_req_o(me_axi_req), .me_wait_for_axi_o(me_wait_for_axi),
    .pc_stall_o(pc_stall), .if_id_stall_o(if_id_stall), .if_id_flush_o(if_id_flush),
    .id_ex_stall_o(id_ex_stall), .id_ex_bubble_o(id_ex_bubble),
    .me_wb_bubble_o(me_wb_bubble), .redirect_take_o(redirect_take),
    .axi_timeout_o(axi_timeout), .stall_cycles_o(stall_cycles), .flush_count_o(flush_count)
  );

  // {axi_req, wait, pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_bubble, wb_bubble, take, timeout}
  function automatic logic [9:0] outs();
    return {me_axi_req, me_wait_for_axi, pc_stall, if_id_stall, if_id_flush,
            id_ex_stall, id_ex_bubble, me_wb_bubble, redirect_take, axi_timeout};
  endfunction

  task automatic clr();
    if_busy = 0; me_mem_req = 0; me_axi_ready = 0; me_axi_done = 0;
    ex_redirect = 0; ex_is_load = 0; ex_rd = 0; id_rs1 = 0; id_rs2 = 0;
    id_use_rs1 = 0; id_use_rs2 = 0;
  endtask

  task automatic nxt();
    @(posedge clk); #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1; clr();
    repeat (3) nxt();
    rst = 0;
  endtask

  task automatic test_reset();
    rst = 1; clr();
    me_mem_req = 1; ex_redirect = 1; if_busy = 1;
    nxt(); nxt();
    smp();
    checks++;
    if (outs() !== 10'd0) begin
      errors++; $display("FAIL reset_hold outs=%b exp=%b", outs(), 10'd0);
    end
    nxt();
    rst = 0; clr();
    smp();
    checks++;
    if (outs() !== 10'd0 || stall_cycles !== 0 || flush_count !== 0) begin
      errors++;
      $display("FAIL reset_release outs=%b stall=%0d flush=%0d exp all 0", outs(), stall_cycles, flush_count);
    end
    nxt();
    me_mem_req = 1;
    smp();
    checks++;
    if (me_wait_for_axi !== 1'b1 || me_axi_req !== 1'b0) begin
      errors++; $display("FAIL reset_idle wait=%b req=%b exp 1 0", me_wait_for_axi, me_axi_req);
    end
    nxt(); clr();
  endtask

  task automatic test_mem_op();
    do_reset();
    for (int c = 0; c <= 6; c++) begin
      me_mem_req = 1; me_axi_ready = (c == 2); me_axi_done = (c == 5);
      smp();
      checks++;
      if (me_wait_for_axi !== (c <= 5) || me_axi_req !== (c == 1 || c == 2) ||
          me_wb_bubble !== (c <= 5) || pc_stall !== (c <= 5)) begin
        errors++;
        $display("FAIL mem_op c=%0d wait=%b req=%b wbb=%b pcs=%b exp wait=%b req=%b",
                 c, me_wait_for_axi, me_axi_req, me_wb_bubble, pc_stall, c <= 5, c == 1 || c == 2);
      end
      nxt();
    end
    clr();
    smp();
    checks++;
    if (stall_cycles !== 8'd6 || me_wait_for_axi !== 1'b0 || me_axi_req !== 1'b0) begin
      errors++; $display("FAIL mem_op_stalls got=%0d exp=6 wait=%b", stall_cycles, me_wait_for_axi);
    end
    nxt();
  endtask

  task automatic test_load_use();
    do_reset();
    ex_is_load = 1; ex_rd = 5; id_use_rs2 = 1; id_rs2 = 5;
    smp();
    checks++;
    if ({pc_stall, if_id_stall, id_ex_bubble, if_id_flush, id_ex_stall} !== 5'b11100) begin
      errors++;
      $display("FAIL load_use_hit got=%b exp=11100", {pc_stall, if_id_stall, id_ex_bubble, if_id_flush, id_ex_stall});
    end
    nxt();
    ex_rd = 0; id_rs2 = 0;
    smp();
    checks++;
    if ({pc_stall, if_id_stall, id_ex_bubble} !== 3'b000) begin
      errors++; $display("FAIL load_use_x0 got=%b exp=000", {pc_stall, if_id_stall, id_ex_bubble});
    end
    nxt();
    ex_rd = 7; id_rs1 = 7; id_use_rs1 = 0; id_use_rs2 = 0;
    smp();
    checks++;
    if (pc_stall !== 1'b0) begin
      errors++; $display("FAIL load_use_unused got=%b exp=0", pc_stall);
    end
    nxt();
    id_use_rs1 = 1;
    smp();
    checks++;
    if ({pc_stall, if_id_stall, id_ex_bubble} !== 3'b111) begin
      errors++; $display("FAIL load_use_rs1 got=%b exp=111", {pc_stall, if_id_stall, id_ex_bubble});
    end
    nxt(); clr();
  endtask

  task automatic test_redirect_in_wait();
    do_reset();
    for (int c = 0; c <= 6; c++) begin
      me_mem_req = (c <= 5); me_axi_ready = (c == 1); me_axi_done = (c == 4);
      ex_redirect = (c == 2);
      smp();
      checks++;
      if (redirect_take !== (c == 5) || (c == 5 && (if_id_flush !== 1'b1 || id_ex_bubble !== 1'b1))) begin
        errors++;
        $display("FAIL redir_wait c=%0d take=%b flush=%b bub=%b exp take=%b",
                 c, redirect_take, if_id_flush, id_ex_bubble, c == 5);
      end
      nxt();
    end
    clr();
    smp();
    checks++;
    if (flush_count !== 8'd1 || redirect_take !== 1'b0) begin
      errors++; $display("FAIL redir_wait_count got=%0d take=%b exp=1 0", flush_count, redirect_take);
    end
    nxt();
  endtask

  task automatic test_priority();
    do_reset();
    ex_redirect = 1; ex_is_load = 1; ex_rd = 3; id_use_rs1 = 1; id_rs1 = 3; if_busy = 1;
    smp();
    checks++;
    if ({redirect_take, if_id_flush, id_ex_bubble, pc_stall, if_id_stall} !== 5'b11100) begin
      errors++;
      $display("FAIL prio_redirect got=%b exp=11100", {redirect_take, if_id_flush, id_ex_bubble, pc_stall, if_id_stall});
    end
    nxt();
    ex_redirect = 0;
    smp();
    checks++;
    if ({pc_stall, if_id_stall, if_id_flush, id_ex_bubble} !== 4'b1101) begin
      errors++; $display("FAIL prio_loaduse got=%b exp=1101", {pc_stall, if_id_stall, if_id_flush, id_ex_bubble});
    end
    nxt();
    ex_is_load = 0;
    smp();
    checks++;
    if ({pc_stall, if_id_stall, if_id_flush, id_ex_bubble} !== 4'b1010) begin
      errors++; $display("FAIL prio_busy got=%b exp=1010", {pc_stall, if_id_stall, if_id_flush, id_ex_bubble});
    end
    nxt(); clr();
  endtask

  task automatic test_timeout();
    do_reset();
    me_mem_req = 1; nxt();
    me_axi_ready = 1; nxt();
    me_axi_ready = 0;
    for (int k = 1; k <= 20; k++) begin
      smp();
      checks++;
      if (axi_timeout !== (k >= int'(MAX_WAIT))) begin
        errors++; $display("FAIL timeout_k%0d got=%b exp=%b", k, axi_timeout, k >= int'(MAX_WAIT));
      end
      nxt();
    end
    me_axi_done = 1; nxt();
    me_axi_done = 0; me_mem_req = 0;
    for (int k = 0; k < 2; k++) begin
      smp();
      checks++;
      if (axi_timeout !== 1'b1) begin
        errors++; $display("FAIL timeout_sticky%0d got=%b exp=1", k, axi_timeout);
      end
      nxt();
    end
    rst = 1; nxt(); rst = 0;
    smp();
    checks++;
    if (axi_timeout !== 1'b0) begin
      errors++; $display("FAIL timeout_clear got=%b exp=0", axi_timeout);
    end
    nxt();
  endtask

  task automatic test_reset_mid();
    do_reset();
    me_mem_req = 1; nxt();
    me_axi_ready = 1; nxt();
    me_axi_ready = 0; nxt();
    rst = 1; nxt();
    rst = 0; me_mem_req = 0; me_axi_done = 1;
    smp();
    checks++;
    if (me_wait_for_axi !== 1'b0 || me_axi_req !== 1'b0) begin
      errors++; $display("FAIL reset_mid wait=%b req=%b exp 0 0", me_wait_for_axi, me_axi_req);
    end
    nxt();
    me_axi_done = 0; me_mem_req = 1;
    smp();
    checks++;
    if (me_wait_for_axi !== 1'b1 || me_axi_req !== 1'b0) begin
      errors++; $display("FAIL done_in_idle wait=%b req=%b exp 1 0", me_wait_for_axi, me_axi_req);
    end
    nxt();
    me_axi_done = 1;
    smp();
    checks++;
    if (me_axi_req !== 1'b1 || me_wait_for_axi !== 1'b1) begin
      errors++; $display("FAIL done_in_req req=%b wait=%b exp 1 1", me_axi_req, me_wait_for_axi);
    end
    nxt();
    smp();
    checks++;
    if (me_axi_req !== 1'b1) begin
      errors++; $display("FAIL done_in_req_hold req=%b exp 1", me_axi_req);
    end
    nxt(); clr();
  endtask

  task automatic test_saturation();
    do_reset();
    if_busy = 1;
    repeat (SAT + 5) nxt();
    if_busy = 0;
    smp();
    checks++;
    if (stall_cycles !== 8'(SAT)) begin
      errors++; $display("FAIL stall_sat got=%0d exp=%0d", stall_cycles, SAT);
    end
    nxt();
    ex_redirect = 1;
    repeat (SAT + 5) nxt();
    ex_redirect = 0;
    smp();
    checks++;
    if (flush_count !== 8'(SAT) || stall_cycles !== 8'(SAT)) begin
      errors++; $display("FAIL flush_sat got=%0d stall=%0d exp=%0d", flush_count, stall_cycles, SAT);
    end
    nxt();
  endtask

  task automatic test_random();
    bit mb, ma, mf, mpend, mto;
    int mcnt, mstall, mflush;
    bit idle, inwait, w, rd, lu, ep, es, efl, eb, et, eto;
    logic [9:0] expv;
    do_reset();
    mb = 0; ma = 0; mf = 0; mpend = 0; mto = 0; mcnt = 0; mstall = 0; mflush = 0;
    for (int n = 0; n < 3000; n++) begin
      rst          = ($urandom_range(0, 199) == 0);
      me_mem_req   = ($urandom_range(0, 2) == 0);
      me_axi_ready = ($urandom_range(0, 1) == 0);
      me_axi_done  = ($urandom_range(0, 3) == 0);
      ex_redirect  = ($urandom_range(0, 5) == 0);
      ex_is_load   = ($urandom_range(0, 1) == 0);
      ex_rd        = 5'($urandom_range(0, 7));
      id_rs1       = 5'($urandom_range(0, 7));
      id_rs2       = 5'($urandom_range(0, 7));
      id_use_rs1   = 1'($urandom_range(0, 1));
      id_use_rs2   = 1'($urandom_range(0, 1));
      if_busy      = ($urandom_range(0, 3) == 0);
      smp();
      idle   = !mb && !mf;
      inwait = mb && ma;
      w      = (idle && me_mem_req) || mb;
      rd     = ex_redirect || mpend;
      lu     = ex_is_load && ex_rd != 0 &&
               ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
      ep     = w || (!rd && (lu || if_busy));
      es     = w || (!rd && lu);
      efl    = !w && (rd || (!lu && if_busy));
      eb     = !w && (rd || lu);
      et     = !w && rd;
      eto    = mto || (inwait && mcnt + 1 >= int'(MAX_WAIT));
      expv   = rst ? 10'd0 : {mb && !ma, w, ep, es, efl, w, eb, w, et, eto};
      checks++;
      if (outs() !== expv) begin
        errors++; $display("FAIL rand_outs n=%0d got=%b exp=%b", n, outs(), expv);
      end
      checks++;
      if (stall_cycles !== 8'(mstall) || flush_count !== 8'(mflush)) begin
        errors++;
        $display("FAIL rand_counters n=%0d stall=%0d/%0d flush=%0d/%0d", n, stall_cycles, mstall, flush_count, mflush);
      end
      if (rst) begin
        mb = 0; ma = 0; mf = 0; mpend = 0; mto = 0; mcnt = 0; mstall = 0; mflush = 0;
      end else begin
        if (ep && mstall < SAT) mstall++;
        if (et && mflush < SAT) mflush++;
        mpend = w ? rd : 1'b0;
        mto   = eto;
        if (inwait) mcnt = me_axi_done ? 0 : mcnt + 1;
        else mcnt = 0;
        if (mf) mf = 0;
        else if (idle) begin
          if (me_mem_req) begin mb = 1; ma = 0; end
        end else if (!ma) begin
          if (me_axi_ready) begin
            if (me_axi_done) begin mb = 0; mf = 1; end
            else ma = 1;
          end
        end else if (me_axi_done) begin
          mb = 0; ma = 0; mf = 1;
        end
      end
      nxt();
    end
    rst = 0; clr();
  endtask

  initial begin
    rst = 1; clr();
    nxt();
    test_reset();
    test_mem_op();
    test_load_use();
    test_redirect_in_wait();
    test_priority();
    test_timeout();
    test_reset_mid();
    test_saturation();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
